// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: hazard inputs, imem handshake and PC/IF-ID controls of the fetch controller
interface fetch_ctrl_if;
    logic        redirect_i;
    logic        stall_i;
    logic        imem_ack;
    logic        imem_req;
    logic        PCWrite;
    logic        PCSel;
    logic        ifid_write;
    logic        ifid_flush;
    logic        fetch_err;
    logic [31:0] fetch_cnt;
    modport master (
        input  redirect_i, stall_i, imem_ack,
        output imem_req, PCWrite, PCSel, ifid_write, ifid_flush, fetch_err, fetch_cnt
    );
    modport slave (
        output redirect_i, stall_i, imem_ack,
        input  imem_req, PCWrite, PCSel, ifid_write, ifid_flush, fetch_err, fetch_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for PC/IF-ID control over a variable-latency imem with ack watchdog
module fetch_ctrl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W = 4
) (
    input logic         clk,
    input logic         rst_n,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN, ERR} state_t;
    state_t           state, nxt;
    logic [CNT_W-1:0] wcnt;
    logic [31:0]      cnt_q;
    logic             err_q;
    logic             busy;
    logic             timeout;
    assign busy    = (state == FETCH) || (state == DRAIN);
    assign timeout = busy && !bus.imem_ack && (wcnt == CNT_W'(ACK_TIMEOUT));
    always_comb begin
        nxt            = state;
        bus.imem_req   = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCSel      = 1'b0;
        bus.ifid_write = 1'b0;
        bus.ifid_flush = 1'b0;
        if (state == BOOT) begin
            nxt = FETCH;
        end else if (state == FETCH) begin
            bus.imem_req = 1'b1;
            if (bus.redirect_i) begin
                bus.PCWrite    = 1'b1;
                bus.PCSel      = 1'b1;
                bus.ifid_flush = 1'b1;
                nxt            = bus.imem_ack ? FETCH : DRAIN;
            end else if (!bus.stall_i && bus.imem_ack) begin
                bus.ifid_write = 1'b1;
                bus.PCWrite    = 1'b1;
            end
        end else if (state == DRAIN) begin
            // the stale response of the squashed request must still be absorbed here
            if (bus.redirect_i) begin
                bus.PCWrite    = 1'b1;
                bus.PCSel      = 1'b1;
                bus.ifid_flush = 1'b1;
            end
            if (bus.imem_ack) nxt = FETCH;
        end
        if (timeout) nxt = ERR;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            wcnt  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= nxt;
            if (timeout) err_q <= 1'b1;
            if (bus.ifid_write) cnt_q <= cnt_q + 32'd1;
            wcnt <= (bus.imem_ack || nxt != state) ? '0 : busy ? wcnt + 1'b1 : wcnt;
        end
    end
    assign bus.fetch_err = err_q;
    assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with an expectation queue checked by an independent negedge monitor
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fetch_ctrl_if bus ();
    fetch_ctrl #(.ACK_TIMEOUT(15), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {
        logic [4:0]  v;
        logic        e;
        logic [31:0] c;
    } exp_t;
    exp_t q[$];
    exp_t x;
    int total = 0;
    int bad = 0;
    logic [4:0] got;
    // vector order {imem_req, PCWrite, PCSel, ifid_write, ifid_flush}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            got = {bus.imem_req, bus.PCWrite, bus.PCSel, bus.ifid_write, bus.ifid_flush};
            total++;
            if (got !== x.v) begin
                bad++;
                $display("FAIL comb_out got=%b want=%b t=%0t", got, x.v, $time);
            end
            total++;
            if (bus.fetch_err !== x.e || bus.fetch_cnt !== x.c) begin
                bad++;
                $display("FAIL regs got err=%b cnt=%h want err=%b cnt=%h t=%0t",
                         bus.fetch_err, bus.fetch_cnt, x.e, x.c, $time);
            end
            total++;
            if (bus.ifid_write && bus.ifid_flush) begin
                bad++;
                $display("FAIL write_flush both high t=%0t", $time);
            end
        end
    end
    task automatic step(input logic r, input logic s, input logic a,
                        input logic [4:0] v, input logic e, input logic [31:0] c);
        @(posedge clk);
        #1;
        bus.redirect_i = r;
        bus.stall_i    = s;
        bus.imem_ack   = a;
        q.push_back('{v: v, e: e, c: c});
    endtask
    // asserts reset with busy inputs, checks, then releases into a BOOT cycle
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.redirect_i = 1'b1;
        bus.stall_i    = 1'b0;
        bus.imem_ack   = 1'b1;
        q.push_back('{v: 5'b00000, e: 1'b0, c: 32'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back('{v: 5'b00000, e: 1'b0, c: 32'd0});
    endtask
    initial begin
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        bus.imem_ack   = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 5'b10000, 0, i);
            step(0, 0, 1, 5'b11010, 0, i);
        end
        step(0, 0, 0, 5'b10000, 0, 5);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5'b10000, 0, 5);
        step(0, 0, 1, 5'b11010, 0, 5);
        step(1, 0, 0, 5'b11101, 0, 6);
        step(0, 0, 0, 5'b00000, 0, 6);
        step(0, 0, 1, 5'b00000, 0, 6);
        step(0, 0, 0, 5'b10000, 0, 6);
        step(1, 0, 0, 5'b11101, 0, 6);
        step(1, 1, 0, 5'b01101, 0, 6);
        step(0, 1, 1, 5'b00000, 0, 6);
        step(1, 1, 1, 5'b11101, 0, 6);
        step(0, 0, 1, 5'b11010, 0, 6);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 5'b10000, 0, 7);
        step(0, 0, 1, 5'b00000, 1, 7);
        step(1, 1, 1, 5'b00000, 1, 7);
        step(0, 0, 0, 5'b00000, 1, 7);
        do_reset();
        step(0, 0, 0, 5'b10000, 0, 0);
        @(negedge clk);
        #1;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        step(0, 0, 1, 5'b11010, 0, 32'hFFFF_FFFF);
        step(0, 0, 0, 5'b10000, 0, 32'd0);
        step(0, 0, 1, 5'b11010, 0, 32'd0);
        step(0, 0, 0, 5'b10000, 0, 32'd1);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
